// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pipe_pkg
// Purpose  : Types and constants shared by the fetch pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pipe_pkg;

  localparam int C_PC_W  = 32;
  localparam int C_LANES = 2;
  localparam int C_EXC_W = 8;

  // Packed exception bundle carried alongside every fetch bundle
  typedef logic [C_EXC_W-1:0] exc_t;

  // Full fetch bundle, for stages that prefer a single struct
  typedef struct packed {
    logic [C_PC_W-1:0]  pc;
    logic [C_LANES-1:0] mask;
    exc_t               exc;
  } fetch_bundle_t;

endpackage
`default_nettype wire

// File: rtl/if_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_skid_stage_if
// Purpose  : Handshake and payload signals between PREIF, the skid stage
//            and IF. The stage uses the slave view, its environment the
//            master view.
// Revision : 1.0 - initial release
// ============================================================================
interface if_skid_stage_if
  import cpu_pipe_pkg::*;
#(
  parameter int PC_W  = C_PC_W,
  parameter int LANES = C_LANES,
  parameter int EXC_W = C_EXC_W,
  parameter int CNT_W = 16
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc;
  logic [LANES-1:0] in_mask;
  logic [EXC_W-1:0] in_exc;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [LANES-1:0] out_mask;
  logic [EXC_W-1:0] out_exc;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  flush, in_valid, in_pc, in_mask, in_exc, out_ready,
    output in_ready, out_valid, out_pc, out_mask, out_exc, stall_cnt
  );

  modport master (
    output flush, in_valid, in_pc, in_mask, in_exc, out_ready,
    input  in_ready, out_valid, out_pc, out_mask, out_exc, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_slot
// Purpose  : One bundle register with valid bit, load enable and a
//            synchronous clear. An invalid slot always holds a zero payload.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_slot
  import cpu_pipe_pkg::*;
#(
  parameter int PC_W  = C_PC_W,
  parameter int LANES = C_LANES,
  parameter int EXC_W = C_EXC_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clr,
  input  wire logic             i_load,
  input  wire logic             i_valid,
  input  wire logic [PC_W-1:0]  i_pc,
  input  wire logic [LANES-1:0] i_mask,
  input  wire logic [EXC_W-1:0] i_exc,
  output logic                  o_valid,
  output logic [PC_W-1:0]       o_pc,
  output logic [LANES-1:0]      o_mask,
  output logic [EXC_W-1:0]      o_exc
);

  // Capture on load; loading an invalid bundle zeroes the payload
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      o_valid <= 1'b0;
      o_pc    <= '0;
      o_mask  <= '0;
      o_exc   <= '0;
    end else if (i_load) begin
      o_valid <= i_valid;
      o_pc    <= i_valid ? i_pc   : '0;
      o_mask  <= i_valid ? i_mask : '0;
      o_exc   <= i_valid ? i_exc  : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_skid_stage
// Purpose  : PREIF->IF pipeline register with valid/ready handshake, a
//            one-entry skid buffer, synchronous flush and a saturating
//            stall counter. in_ready is registered so IF/ID backpressure
//            never reaches PC selection combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module if_skid_stage
  import cpu_pipe_pkg::*;
#(
  parameter int PC_W  = C_PC_W,
  parameter int LANES = C_LANES,
  parameter int EXC_W = C_EXC_W,
  parameter int CNT_W = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  if_skid_stage_if.slave bus
);

  logic             w_main_v;
  logic [PC_W-1:0]  w_main_pc;
  logic [LANES-1:0] w_main_mask;
  logic [EXC_W-1:0] w_main_exc;
  logic             w_skid_v;
  logic [PC_W-1:0]  w_skid_pc;
  logic [LANES-1:0] w_skid_mask;
  logic [EXC_W-1:0] w_skid_exc;

  logic             r_in_ready;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_acc;
  logic w_cons;
  logic w_main_load;
  logic w_main_d_v;
  logic w_skid_load;
  logic w_full_nxt;

  // Handshake events; the state is just the pair (main valid, skid valid)
  assign w_acc  = bus.in_valid & r_in_ready;
  assign w_cons = w_main_v & bus.out_ready;

  // Main refills when empty and accepting, or whenever its bundle leaves.
  // Skid (if occupied) always comes first so ordering stays FIFO; with
  // nothing to refill from, main loads an invalid (zeroed) entry.
  assign w_main_load = (!w_main_v & w_acc) | w_cons;
  assign w_main_d_v  = w_skid_v | w_acc;

  // Skid captures only when main is occupied and stays so; it empties on
  // the consume that moves its bundle into main.
  assign w_skid_load = (w_main_v & !w_cons & w_acc) | (w_skid_v & w_cons);

  // Both slots valid after this edge
  assign w_full_nxt = w_main_v & !w_cons & (w_acc | w_skid_v);

  pipe_slot #(
    .PC_W  (PC_W),
    .LANES (LANES),
    .EXC_W (EXC_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.flush),
    .i_load  (w_main_load),
    .i_valid (w_main_d_v),
    .i_pc    (w_skid_v ? w_skid_pc   : bus.in_pc),
    .i_mask  (w_skid_v ? w_skid_mask : bus.in_mask),
    .i_exc   (w_skid_v ? w_skid_exc  : bus.in_exc),
    .o_valid (w_main_v),
    .o_pc    (w_main_pc),
    .o_mask  (w_main_mask),
    .o_exc   (w_main_exc)
  );

  pipe_slot #(
    .PC_W  (PC_W),
    .LANES (LANES),
    .EXC_W (EXC_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.flush),
    .i_load  (w_skid_load),
    .i_valid (!w_skid_v),
    .i_pc    (bus.in_pc),
    .i_mask  (bus.in_mask),
    .i_exc   (bus.in_exc),
    .o_valid (w_skid_v),
    .o_pc    (w_skid_pc),
    .o_mask  (w_skid_mask),
    .o_exc   (w_skid_exc)
  );

  // Ready for the next cycle: low only while both slots are occupied
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= !w_full_nxt;
    end
  end

  // Saturating count of stalled output cycles; flush leaves it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_main_v && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_main_v;
  assign bus.out_pc    = w_main_pc;
  assign bus.out_mask  = w_main_mask;
  assign bus.out_exc   = w_main_exc;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_skid_stage
// Purpose  : Self-checking bench for if_skid_stage: directed scenarios with
//            literal expectations followed by randomized traffic compared
//            against a queue-based model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_skid_stage;

  localparam int PC_W    = 32;
  localparam int LANES   = 2;
  localparam int EXC_W   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [LANES-1:0] mask;
    logic [EXC_W-1:0] exc;
  } bnd_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   chk_en;

  bnd_t mq[$];
  int   mcnt;

  if_skid_stage_if #(
    .PC_W  (PC_W),
    .LANES (LANES),
    .EXC_W (EXC_W),
    .CNT_W (CNT_W)
  ) bus ();

  if_skid_stage #(
    .PC_W  (PC_W),
    .LANES (LANES),
    .EXC_W (EXC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two bundles, updated on each edge
  always @(posedge clk) begin : model
    bit m_cons;
    bit m_acc;
    if (rst) begin
      mq.delete();
      mcnt   = 0;
      chk_en = 1'b1;
    end else begin
      if (mq.size() > 0 && !bus.out_ready && mcnt < CNT_MAX) mcnt++;
      if (bus.flush) begin
        mq.delete();
      end else begin
        m_cons = (mq.size() > 0) && bus.out_ready;
        m_acc  = bus.in_valid && (mq.size() < 2);
        if (m_cons) void'(mq.pop_front());
        if (m_acc)  mq.push_back('{pc: bus.in_pc, mask: bus.in_mask, exc: bus.in_exc});
      end
    end
  end

  // Every cycle, mid-period: DUT outputs against the model
  always @(negedge clk) begin
    bnd_t h;
    if (chk_en) begin
      h = (mq.size() > 0) ? mq[0] : '0;
      check("m_out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
      check("m_out_pc",    64'(bus.out_pc),    64'(h.pc));
      check("m_out_mask",  64'(bus.out_mask),  64'(h.mask));
      check("m_out_exc",   64'(bus.out_exc),   64'(h.exc));
      check("m_in_ready",  64'(bus.in_ready),  64'(mq.size() < 2));
      check("m_stall_cnt", 64'(bus.stall_cnt), 64'(mcnt));
    end
  end

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [LANES-1:0] mask,
                       input logic [EXC_W-1:0] exc, input logic ordy, input logic fl, input logic r);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_mask   = mask;
    bus.in_exc    = exc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    rst           = r;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    mcnt     = 0;

    // Reset held two cycles while a bundle is offered
    drive(1, 32'h1234, 2'b11, 8'h00, 1, 0, 1);
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check("rst_out_pc",    64'(bus.out_pc),    64'd0);

    // First accept after release
    drive(1, 32'hBFC00000, 2'b11, 8'h00, 1, 0, 0);
    tick();
    check("first_valid", 64'(bus.out_valid), 64'd1);
    check("first_pc",    64'(bus.out_pc),    64'hBFC00000);

    // Streaming without bubbles
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 32'(8 * i), 2'b11, 8'h00, 1, 0, 0);
      tick();
      check("stream_valid", 64'(bus.out_valid), 64'd1);
      check("stream_pc",    64'(bus.out_pc),    64'h100 + 64'(8 * i));
    end
    drive(0, 32'h0, 2'b00, 8'h00, 1, 0, 0);
    tick();
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure into the skid slot
    drive(1, 32'h200, 2'b11, 8'h00, 0, 0, 0);
    tick();
    check("bp_pc0", 64'(bus.out_pc), 64'h200);
    check("bp_rdy0", 64'(bus.in_ready), 64'd1);
    drive(1, 32'h208, 2'b11, 8'h00, 0, 0, 0);
    tick();
    check("bp_rdy1", 64'(bus.in_ready), 64'd0);
    check("bp_pc1",  64'(bus.out_pc),   64'h200);
    drive(1, 32'h210, 2'b11, 8'h00, 0, 0, 0);
    tick();
    tick();
    check("bp_hold_pc", 64'(bus.out_pc), 64'h200);
    drive(1, 32'h210, 2'b11, 8'h00, 1, 0, 0);
    tick();
    check("bp_out208", 64'(bus.out_pc),   64'h208);
    check("bp_rdy2",   64'(bus.in_ready), 64'd1);
    tick();
    check("bp_out210", 64'(bus.out_pc), 64'h210);
    drive(0, 32'h0, 2'b00, 8'h00, 1, 0, 0);
    tick();
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // Saturating stall counter, then flush from FULL
    drive(1, 32'h400, 2'b11, 8'h00, 0, 0, 0);
    tick();
    drive(1, 32'h408, 2'b11, 8'h00, 0, 0, 0);
    tick();
    drive(0, 32'h0, 2'b00, 8'h00, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt", 64'(bus.stall_cnt), 64'd15);
    drive(1, 32'h300, 2'b11, 8'h11, 0, 1, 0);
    tick();
    check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_pc",    64'(bus.out_pc),    64'd0);
    check("fl_mask",  64'(bus.out_mask),  64'd0);
    check("fl_exc",   64'(bus.out_exc),   64'd0);
    check("fl_rdy",   64'(bus.in_ready),  64'd1);
    check("fl_cnt",   64'(bus.stall_cnt), 64'd15);
    drive(0, 32'h0, 2'b00, 8'h00, 1, 0, 0);
    tick();
    check("fl_dropped", 64'(bus.out_valid), 64'd0);
    drive(0, 32'h0, 2'b00, 8'h00, 1, 0, 1);
    tick();
    check("rst_cnt", 64'(bus.stall_cnt), 64'd0);

    // Exception-only bundle
    drive(1, 32'h500, 2'b00, 8'h05, 1, 0, 0);
    tick();
    check("exc_valid", 64'(bus.out_valid), 64'd1);
    check("exc_mask",  64'(bus.out_mask),  64'd0);
    check("exc_exc",   64'(bus.out_exc),   64'h05);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 4) != 0, $urandom, 2'($urandom), 8'($urandom),
            ($urandom % 3) != 0, ($urandom % 20) == 0, ($urandom % 97) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
